led_pattern_sequencer: RTL and testbench

//   Sequences the board LED bank (pin_d1..pin_d5) through selectable animated patterns with

---
 rtl/led_pattern_sequencer.sv | 121 ++++++++++++
 tb/tb_led_pattern_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Drives the LED bank through OFF / CHASE / BOUNCE / BLINK patterns with global PWM dimming.
// Mode and brightness are loaded through a valid/ready handshake and take effect on the next cycle.
module led_pattern_sequencer #(
  parameter int N_LEDS   = 5,
  parameter int TICK_DIV = 1200000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode_valid,
  output logic                mode_ready,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]   led,
  output logic                step_strobe
);

  // state  | meaning
  // OFF    | all LEDs dark, pattern frozen at zero
  // CHASE  | single lit LED rotating toward MSB, wraps to LSB
  // BOUNCE | single lit LED sweeping MSB-ward then LSB-ward
  // BLINK  | whole bank toggling between all-on and all-off
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_CHASE  = 2'd1,
    ST_BOUNCE = 2'd2,
    ST_BLINK  = 2'd3
  } state_t;

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] TICK_LAST = PS_W'(TICK_DIV - 1);
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  state_t                state_q, state_d;
  logic [N_LEDS-1:0]     pattern_q, pattern_d;
  logic                  dir_q, dir_d;
  logic [PS_W-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  logic                  ready_q, ready_d;
  logic                  strobe_q, strobe_d;
  logic [N_LEDS-1:0]     led_q, led_d;
  logic                  accept;
  logic                  tick;
  logic                  gate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OFF;
      pattern_q <= '0;
      dir_q     <= DIR_LEFT;
      presc_q   <= '0;
      pwm_q     <= '0;
      bright_q  <= '1;
      ready_q   <= 1'b1;
      strobe_q  <= 1'b0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      bright_q  <= bright_d;
      ready_q   <= ready_d;
      strobe_q  <= strobe_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    accept    = mode_valid && ready_q;
    tick      = (presc_q == TICK_LAST);
    gate      = (pwm_q < bright_q) || (&bright_q);
    state_d   = state_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    presc_d   = tick ? '0 : presc_q + PS_W'(1);
    pwm_d     = pwm_q + PWM_BITS'(1);
    bright_d  = bright_q;
    ready_d   = !accept;
    strobe_d  = 1'b0;
    led_d     = pattern_q & {N_LEDS{gate}};

    // An accept in a tick cycle swallows that tick: the new pattern starts a full step.
    if (accept) begin
      state_d  = state_t'(mode);
      bright_d = brightness;
      presc_d  = '0;
      dir_d    = DIR_LEFT;
      case (state_t'(mode))
        ST_CHASE:  pattern_d = N_LEDS'(1);
        ST_BOUNCE: pattern_d = N_LEDS'(1);
        ST_BLINK:  pattern_d = '1;
        default:   pattern_d = '0;
      endcase
    end else if (tick) begin
      strobe_d = (state_q != ST_OFF);
      case (state_q)
        ST_CHASE:  pattern_d = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
        ST_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            pattern_d = pattern_q << 1;
            if (pattern_q[N_LEDS-2]) dir_d = DIR_RIGHT;
          end else begin
            pattern_d = pattern_q >> 1;
            if (pattern_q[1]) dir_d = DIR_LEFT;
          end
        end
        ST_BLINK:  pattern_d = ~pattern_q;
        default:   pattern_d = '0;
      endcase
    end
  end

  assign mode_ready  = ready_q;
  assign step_strobe = strobe_q;
  assign led         = led_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer; expected outputs come from a closed-form
// pattern model keyed on cycles since the last accepted request, queued then compared.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_valid = 1'b0;
  logic       mode_ready;
  logic [1:0] mode = 2'd0;
  logic [3:0] brightness = 4'd0;
  logic [4:0] led;
  logic       step_strobe;

  led_pattern_sequencer #(.N_LEDS(5), .TICK_DIV(4), .PWM_BITS(4)) dut (
    .clk(clk), .rst(rst), .mode_valid(mode_valid), .mode_ready(mode_ready),
    .mode(mode), .brightness(brightness), .led(led), .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] led;
    logic       strobe;
    logic       ready;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [3:0] pwm_m;
  logic [3:0] bright_m;
  logic [4:0] pat_m;
  logic [1:0] mode_m;
  bit         rdy_m;
  bit         active;
  bit         last_acc;
  int         t;
  int         ta;

  function automatic logic [4:0] pat_at(logic [1:0] m, int s);
    int p;
    int pos;
    case (m)
      2'd1: return 5'(1 << (s % 5));
      2'd2: begin
        p   = s % 8;
        pos = (p < 5) ? p : 8 - p;
        return 5'(1 << pos);
      end
      2'd3: return ((s % 2) == 0) ? 5'b11111 : 5'b00000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s t=%0d: observed=%0h expected=%0h", tag, t, obs, expv);
    end
  endtask

  task automatic model_reset();
    pwm_m    = 4'd0;
    bright_m = 4'hF;
    pat_m    = 5'd0;
    mode_m   = 2'd0;
    rdy_m    = 1'b1;
    active   = 1'b0;
    t        = 0;
    ta       = 0;
    sb.delete();
  endtask

  task automatic cycle();
    exp_t e;
    exp_t o;
    bit   acc;
    int   k;
    acc   = mode_valid && rdy_m;
    e.led = ((pwm_m < bright_m) || (bright_m == 4'hF)) ? pat_m : 5'b00000;
    pwm_m = pwm_m + 4'd1;
    t++;
    if (acc) begin
      ta       = t;
      mode_m   = mode;
      bright_m = brightness;
      active   = 1'b1;
    end
    k = t - ta;
    if (active) begin
      pat_m    = pat_at(mode_m, k / 4);
      e.strobe = (mode_m != 2'd0) && (k > 0) && ((k % 4) == 0);
    end else begin
      pat_m    = 5'd0;
      e.strobe = 1'b0;
    end
    e.ready  = !acc;
    rdy_m    = !acc;
    last_acc = acc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("led", 32'(led), 32'(o.led));
    chk("step_strobe", 32'(step_strobe), 32'(o.strobe));
    chk("mode_ready", 32'(mode_ready), 32'(o.ready));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic request(logic [1:0] m, logic [3:0] b);
    bit done;
    done       = 1'b0;
    mode_valid = 1'b1;
    mode       = m;
    brightness = b;
    for (int i = 0; i < 4 && !done; i++) begin
      cycle();
      done = last_acc;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout mode=%0d: observed=no accept expected=accept", m);
    end
    mode_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_ready", 32'(mode_ready), 32'd1);
    chk("rst_strobe", 32'(step_strobe), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    run(20);

    request(2'd1, 4'd15);
    run(24);

    request(2'd2, 4'd15);
    run(40);

    request(2'd3, 4'd4);
    run(40);
    request(2'd3, 4'd0);
    run(20);

    // Request timed to coincide with a tick, then a second request held through ready=0
    request(2'd1, 4'd15);
    for (int i = 0; i < 8 && ((t - ta) % 4) != 3; i++) cycle();
    request(2'd1, 4'd15);
    request(2'd3, 4'd15);
    run(12);

    // Async reset while BOUNCE is sweeping right (pattern 01000)
    request(2'd2, 4'd15);
    run(22);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led), 32'd0);
    chk("async_rst_ready", 32'(mode_ready), 32'd1);
    chk("async_rst_strobe", 32'(step_strobe), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    request(2'd2, 4'd15);
    run(20);

    request(2'd0, 4'd15);
    run(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
